// File: rtl/exu_mul_pipe.sv
// exu_mul_pipe: fully pipelined XLEN x XLEN integer multiplier.
// One op per cycle under valid/ready, STAGES cycles of latency, in-order
// completion with backpressure, flush, and a passthrough tag.
// Optional: define EXU_MUL_PERF_CNT_EN to add the perf_mul_cnt output,
// a 32-bit count of accepted operations.
module exu_mul_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mul_signed,
  input  logic             mul_low,
  input  logic [XLEN-1:0]  src0,
  input  logic [XLEN-1:0]  src1,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag
`ifdef EXU_MUL_PERF_CNT_EN
  ,
  output logic [31:0]      perf_mul_cnt
`endif
);

  localparam int unsigned NS = STAGES;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] adv;
  logic              accept;

  // Slot 0 holds the captured operands; later slots hold the selected half.
  logic              s0_sgn;
  logic              s0_low;
  logic [XLEN-1:0]   s0_a;
  logic [XLEN-1:0]   s0_b;
  logic [TAG_W-1:0]  tag_q [STAGES];

  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] b_ext;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   s0_half;

  // Advance chain, resolved from the output slot back toward slot 0.
  always_comb begin
    int unsigned k;
    adv        = '0;
    adv[NS-1]  = vld_q[NS-1] & out_ready;
    for (int unsigned i = 1; i < NS; i++) begin
      k      = NS - 1 - i;
      adv[k] = vld_q[k] & (~vld_q[k+1] | adv[k+1]);
    end
  end

  assign in_ready  = ~vld_q[0] | adv[0];
  assign accept    = in_valid & in_ready & ~flush;
  assign out_valid = vld_q[NS-1];
  assign out_tag   = tag_q[NS-1];

  // Extending both operands to 2*XLEN makes the low 2*XLEN bits of an
  // unsigned multiply equal to the signed product when sign-extended.
  always_comb begin
    a_ext   = {{XLEN{s0_sgn & s0_a[XLEN-1]}}, s0_a};
    b_ext   = {{XLEN{s0_sgn & s0_b[XLEN-1]}}, s0_b};
    prod    = a_ext * b_ext;
    s0_half = s0_low ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // Slot valid bits: flush wins over accept and advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= accept | (vld_q[0] & ~adv[0]);
      for (int unsigned k = 1; k < NS; k++) begin
        vld_q[k] <= adv[k-1] | (vld_q[k] & ~adv[k]);
      end
    end
  end

  // Operand capture into slot 0 and tag shift along the slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_sgn <= 1'b0;
      s0_low <= 1'b0;
      s0_a   <= '0;
      s0_b   <= '0;
      for (int unsigned k = 0; k < NS; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      if (accept) begin
        s0_sgn   <= mul_signed;
        s0_low   <= mul_low;
        s0_a     <= src0;
        s0_b     <= src1;
        tag_q[0] <= in_tag;
      end
      for (int unsigned k = 1; k < NS; k++) begin
        if (adv[k-1]) tag_q[k] <= tag_q[k-1];
      end
    end
  end

  generate
    if (STAGES == 1) begin : g_one
      // Single stage: the product is formed directly from the held operands.
      assign result = s0_half;
    end else begin : g_multi
      logic [XLEN-1:0] res_q [1:STAGES-1];

      // Product half registered leaving slot 0, then shifted to the output.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned k = 1; k < NS; k++) begin
            res_q[k] <= '0;
          end
        end else begin
          if (adv[0]) res_q[1] <= s0_half;
          for (int unsigned k = 2; k < NS; k++) begin
            if (adv[k-1]) res_q[k] <= res_q[k-1];
          end
        end
      end

      assign result = res_q[STAGES-1];
    end
  endgenerate

`ifdef EXU_MUL_PERF_CNT_EN
  // Accepted-operation counter; wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_mul_cnt <= '0;
    end else if (accept) begin
      perf_mul_cnt <= perf_mul_cnt + 32'd1;
    end
  end
`else
  // No performance counter in this build.
`endif

endmodule
